// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/dispatch/execute sequencer with MIPS delay-slot PC handling.
// Optional retired-instruction counter enabled by defining SEQ_INSTRET_CNT_EN.
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        exec_done,
    input  logic        exec_branch,
    input  logic [31:0] exec_target,
    input  logic        exec_unknown,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] instret_cnt
);

    typedef enum logic [2:0] {
        FETCH,
        WAIT_DATA,
        DISPATCH,
        EXECUTE,
        HALT
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_UNKNOWN   = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'd2;

    state_t      state;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic [31:0] next_pc;
    logic        retire;

    // A taken branch redirects only after its delay slot has executed.
    assign next_pc = pend_valid ? pend_target : pc + 32'd4;
    assign retire  = (state == EXECUTE) && exec_done && !exec_unknown;

    assign ireq_valid  = (state == FETCH);
    assign ireq_addr   = pc;
    assign instr_valid = (state == DISPATCH);
    assign halted      = (state == HALT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            halt_cause  <= CAUSE_NONE;
        end else begin
            case (state)
                FETCH: begin
                    if (iresp_addr_ok) begin
                        if (iresp_data_ok) begin
                            instr <= iresp_data;
                            state <= DISPATCH;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (iresp_data_ok) begin
                        instr <= iresp_data;
                        state <= DISPATCH;
                    end
                end
                DISPATCH: state <= EXECUTE;
                EXECUTE: begin
                    if (exec_done) begin
                        if (exec_unknown) begin
                            halt_cause <= CAUSE_UNKNOWN;
                            state      <= HALT;
                        end else begin
                            pend_valid <= exec_branch;
                            if (exec_branch) begin
                                pend_target <= exec_target;
                            end
                            pc <= next_pc;
                            if (next_pc[1:0] != 2'b00) begin
                                halt_cause <= CAUSE_MISALIGN;
                                state      <= HALT;
                            end else begin
                                state <= FETCH;
                            end
                        end
                    end
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

`ifdef SEQ_INSTRET_CNT_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret_cnt = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instret_cnt   = 32'h0;
`endif

endmodule
